// File: rtl/mul_add_ctrl_if.sv
// Handshake and datapath-control bundle between the multiplier controller
// and its datapath / operand source. The controller is the master side.
interface mul_add_ctrl_if #(
  parameter int DW = 16
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          eq;
  logic          ldA;
  logic          ldB;
  logic          ldP;
  logic          clrA;
  logic          clrP;
  logic          decB;
  logic          sel;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] iter_cnt;

  modport master (
    input  start, in_valid, eq,
    output in_ready, ldA, ldB, ldP, clrA, clrP, decB, sel,
           busy, done, err, iter_cnt
  );

  modport slave (
    output start, in_valid, eq,
    input  in_ready, ldA, ldB, ldP, clrA, clrP, decB, sel,
           busy, done, err, iter_cnt
  );
endinterface

// File: rtl/mul_add_ctrl.sv
// Control FSM for a repeated-addition multiplier: loads A then B over a
// valid/ready handshake, accumulates A into P once per cycle while B counts
// down to zero, and exits to ERR if the accumulate loop runs too long.
module mul_add_ctrl #(
  parameter int          DW       = 16,
  parameter int unsigned MAX_ITER = 32'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_add_ctrl_if.master bus
);

  localparam logic [DW-1:0] MAX_ITER_W = DW'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_A,
    S_LD_B,
    S_ADD,
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] iter_cnt_q, iter_cnt_d;
  logic [DW-1:0] iter_inc;

  logic in_ready, ld_a, ld_b, ld_p, clr_a, clr_p, dec_b, sel;
  logic busy, done, err;

  assign iter_inc = iter_cnt_q + DW'(1);

  // State register and iteration counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  // Next-state, counter update and strobe decode.
  // NOTE: every output gets a default first so no path through the case
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    in_ready   = 1'b0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_p       = 1'b0;
    clr_a      = 1'b0;
    clr_p      = 1'b0;
    dec_b      = 1'b0;
    sel        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        done = (state_q == S_DONE);
        err  = (state_q == S_ERR);
        // Clearing is gated by rst_n so no strobe leaks out while in reset.
        if (bus.start && rst_n) begin
          clr_a      = 1'b1;
          clr_p      = 1'b1;
          iter_cnt_d = '0;
          state_d    = S_LD_A;
        end
      end
      S_LD_A: begin
        busy     = 1'b1;
        sel      = 1'b1;
        in_ready = 1'b1;
        ld_a     = bus.in_valid;
        if (bus.in_valid) state_d = S_LD_B;
      end
      S_LD_B: begin
        busy     = 1'b1;
        sel      = 1'b1;
        in_ready = 1'b1;
        ld_b     = bus.in_valid;
        if (bus.in_valid) state_d = S_ADD;
      end
      S_ADD: begin
        busy = 1'b1;
        if (!bus.eq) begin
          ld_p       = 1'b1;
          dec_b      = 1'b1;
          iter_cnt_d = iter_inc;
          // Watchdog: the MAX_ITER-th accumulate with B still non-zero.
          if (iter_inc == MAX_ITER_W) state_d = S_ERR;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.ldA      = ld_a;
  assign bus.ldB      = ld_b;
  assign bus.ldP      = ld_p;
  assign bus.clrA     = clr_a;
  assign bus.clrP     = clr_p;
  assign bus.decB     = dec_b;
  assign bus.sel      = sel;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_mul_add_ctrl.sv
// Self-checking bench for mul_add_ctrl: a small datapath model closes the
// loop (A/B/P registers, zero-detect), a driver issues operations and pushes
// the expected outcome, and a monitor compares on each completion.
module tb_mul_add_ctrl;

  localparam int DW       = 16;
  localparam int MAX_ITER = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_add_ctrl_if #(.DW(DW)) bus ();

  mul_add_ctrl #(.DW(DW), .MAX_ITER(MAX_ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Datapath model: registers A, B, P driven by the controller strobes.
  logic [15:0] reg_a = '0, reg_b = '0, reg_p = '0;
  logic [15:0] dp_bus;
  int          ldp_cnt = 0;

  assign dp_bus = bus.sel ? data_in : 16'h0;
  assign bus.eq = (reg_b == 16'h0);

  always @(posedge clk) begin
    if (bus.clrA) reg_a <= '0;
    else if (bus.ldA) reg_a <= dp_bus;
    if (bus.ldB) reg_b <= dp_bus;
    else if (bus.decB) reg_b <= reg_b - 16'd1;
    if (bus.clrP) begin
      reg_p   <= '0;
      ldp_cnt <= 0;
    end else if (bus.ldP) begin
      reg_p   <= reg_p + reg_a;
      ldp_cnt <= ldp_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard entries: outcome expected for one operation.
  typedef struct {
    bit          is_err;
    logic [15:0] p;
    logic [15:0] iter;
    int          edge_n;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: compare on each rising done/err, plus per-cycle strobe rules.
  logic done_prev = 1'b0, err_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    check("ldA_ldB_exclusive", {31'd0, bus.ldA & bus.ldB}, 0);
    check("ldP_decB_only_in_add",
          {31'd0, (bus.ldP | bus.decB) & ~(bus.busy & ~bus.in_ready)}, 0);
    check("sel_low_when_not_ready", {31'd0, bus.sel & ~bus.in_ready}, 0);
    if ((bus.done && !done_prev) || (bus.err && !err_prev)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_completion", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("done_flag", {31'd0, bus.done}, {31'd0, ~e.is_err});
        check("err_flag", {31'd0, bus.err}, {31'd0, e.is_err});
        check("busy_at_end", {31'd0, bus.busy}, 0);
        check("p_result", {16'd0, reg_p}, {16'd0, e.p});
        check("iter_cnt", {16'd0, bus.iter_cnt}, {16'd0, e.iter});
        check("ldP_pulses", ldp_cnt, {16'd0, e.iter});
        check("latency_edge", cyc, e.edge_n);
      end
    end
    done_prev = bus.done;
    err_prev  = bus.err;
  end

  // One operation: start, A after ga idle cycles, B after gb idle cycles,
  // then wait for completion while poking start/in_valid (both ignored).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int ga, input int gb);
    exp_t e;
    int   n;
    int   s;
    int   budget;
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    s = cyc;
    e.is_err = (b >= MAX_ITER);
    n        = e.is_err ? MAX_ITER : int'(b);
    e.p      = 16'(int'(a) * n);
    e.iter   = 16'(n);
    e.edge_n = s - 1 + (e.is_err ? MAX_ITER + 3 : int'(b) + 4) + ga + gb;
    sb_q.push_back(e);
    for (int i = 0; i < ga; i++) begin
      data_in = 16'($urandom);
      @(negedge clk);
      check("gap_a_ready", {31'd0, bus.in_ready}, 1);
      check("gap_a_no_ldA", {31'd0, bus.ldA}, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    data_in      = a;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < gb; i++) begin
      data_in = 16'($urandom);
      @(negedge clk);
      check("gap_b_ready", {31'd0, bus.in_ready}, 1);
      check("gap_b_no_ldB", {31'd0, bus.ldB}, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    data_in      = b;
    @(posedge clk); #1;
    budget = MAX_ITER + 10;
    while (!(bus.done || bus.err) && budget > 0) begin
      bus.start    = ($urandom_range(0, 2) == 0);
      bus.in_valid = 1'($urandom);
      data_in      = 16'($urandom);
      @(posedge clk); #1;
      budget--;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    if (budget == 0) check("completion_timeout", {31'd0, bus.done | bus.err}, 1);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      bus.in_valid = 1'($urandom);
      data_in      = 16'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy}, 0);
    check("reset_done", {31'd0, bus.done}, 0);
    check("reset_err", {31'd0, bus.err}, 0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 0);
    check("reset_iter", {16'd0, bus.iter_cnt}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset pulled on the 2nd ADD cycle of A=3, B=5.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; data_in = 16'd3;
    @(posedge clk); #1;
    data_in = 16'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_iter", {16'd0, bus.iter_cnt}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, bus.busy}, 0);
    check("async_reset_ldP", {31'd0, bus.ldP}, 0);
    check("async_reset_decB", {31'd0, bus.decB}, 0);
    check("async_reset_iter", {16'd0, bus.iter_cnt}, 0);
    check("async_reset_done", {31'd0, bus.done | bus.err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd3, 16'd5, 0, 0);    // fresh start after reset, P=15
    idle_cycles(2);
    run_op(16'd7, 16'd4, 0, 0);    // P=28, done at edge 8
    idle_cycles(1);
    run_op(16'd6, 16'd2, 0, 0);    // start from DONE, P=12
    run_op(16'd9, 16'd0, 0, 0);    // zero accumulations
    run_op(16'd5, 16'd3, 2, 3);    // handshake gaps
    idle_cycles(2);
    run_op(16'd2, 16'd10, 0, 0);   // watchdog trip
    idle_cycles(3);
    run_op(16'd4, 16'd3, 1, 0);    // restart from ERR
    run_op(16'd11, 16'(MAX_ITER - 1), 0, 0);  // longest non-error run
    run_op(16'd1, 16'(MAX_ITER), 0, 1);       // smallest erroring B

    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom_range(0, 255)), 16'($urandom_range(0, MAX_ITER + 3)),
             $urandom_range(0, 3), $urandom_range(0, 3));
      idle_cycles($urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_add_ctrl.md
Name: mul_add_ctrl

Overview:
- Control FSM for the repeated-addition multiplier datapath (16-bit operand bus, registers A/B/P, adder, zero-detect on B).
- Accepts a start request and takes two operand words (A, then B) from an upstream source over a valid/ready handshake.
- Strobes the datapath controls so that P accumulates A once per cycle while B counts down to zero, then signals completion.
- Also counts iterations and provides a watchdog error exit.

Parameters:
- DW, 16, width of data_in and of iter_cnt.
- MAX_ITER, 16'hFFFF, ADD-state cycles allowed before the watchdog error is raised (must be ≥1).

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a multiplication; sampled only in IDLE, DONE, ERR.
- in_valid  input  1  upstream operand word present on datapath data_in.
- in_ready  output  1  controller accepting an operand word this cycle.
- eq  input  1  datapath zero flag (B == 0), combinational from reg B.
- ldA  output  1  load reg A from bus.
- ldB  output  1  load reg B from bus.
- ldP  output  1  load reg P from adder.
- clrA  output  1  clear reg A.
- clrP  output  1  clear reg P.
- decB  output  1  decrement reg B.
- sel  output  1  bus mux select; 1 routes data_in onto bus.
- busy  output  1  operation in progress.
- done  output  1  result valid in P.
- err  output  1  watchdog tripped.
- iter_cnt  output  DW  number of accumulate cycles performed in current/last operation.

Behaviour:
- States: IDLE, LD_A, LD_B, ADD, DONE, ERR. Encoding is free. State register and iter_cnt are reset asynchronously. All strobe outputs decode combinationally from state (plus in_valid and eq where noted); busy, done and err also decode from state.
- Reset (rst_n=0): state=IDLE; iter_cnt=0. All strobes, busy, done, err and in_ready are 0.
- IDLE: all strobes 0. start=1 → LD_A, with clrA=1 and clrP=1 asserted in the same IDLE cycle. iter_cnt cleared to 0 on that edge.
- LD_A: sel=1, in_ready=1, ldA=in_valid. Transition to LD_B on in_valid=1; otherwise stay. busy=1.
- LD_B: sel=1, in_ready=1, ldB=in_valid. Transition to ADD on in_valid=1; otherwise stay. busy=1.
- ADD: sel=0, busy=1.
  - eq=0: ldP=1, decB=1, iter_cnt+1. If iter_cnt+1 == MAX_ITER and eq still 0, then ERR on the same edge; else stay.
  - eq=1: ldP=0, decB=0, transition to DONE. B=0 at entry therefore gives zero accumulations and P=0.
- DONE: done=1, busy=0, strobes 0; P and iter_cnt hold. start=1 → LD_A with clrA and clrP asserted, exactly as from IDLE.
- ERR: err=1, done=0, busy=0, strobes 0. start=1 → LD_A (restart); otherwise hold.
- Strobe exclusivity: ldA and ldB are never asserted in the same cycle. ldP/decB are never asserted outside ADD. sel=0 whenever in_ready=0.
- Latency: start edge to DONE = 1 (IDLE) + A handshake + B handshake + (B+1) ADD cycles. With in_valid held at 1 and start in IDLE, done rises at cycle B+4 after start is sampled.
- start is ignored while busy=1. in_valid is ignored outside LD_A/LD_B.
- rst_n deasserted mid-operation: immediate return to IDLE. Datapath register contents are undefined until the next clrA/clrP.
- iter_cnt is DW bits and does not wrap, because the watchdog fires at MAX_ITER.

Test Plan:
- Reset mid-ADD (A=3, B=5, rst_n pulled low on 2nd ADD cycle) → all outputs 0 and state IDLE asynchronously; a fresh start then yields P=15.
- A=7, B=4, in_valid held at 1 → ldP/decB high for exactly 4 cycles, done at cycle 8 after start, P=28, iter_cnt=4.
- A=9, B=0 → no ldP pulses, done after 4 cycles, P=0, iter_cnt=0.
- A=5, B=3 with in_valid low for 2 cycles in LD_A and 3 cycles in LD_B → in_ready held high and no ldA/ldB during the gaps, P=15.
- MAX_ITER=4, A=2, B=10 → err=1 after 4 ldP pulses, done=0, busy=0; start then restarts at LD_A.
- start pulsed during ADD → ignored. start in DONE with A=6, B=2 → new result P=12, with clrP seen before the first ldP.
